// File: rtl/tlc_pkg.sv
// Shared lamp codes and controller state encoding for the N-approach traffic-light controller.
// Latency: none (definitions only).
// Backpressure: none.
package tlc_pkg;

    // Lamp codes driven per approach onto the 2-bit lamp driver lanes
    localparam logic [1:0] LAMP_GREEN  = 2'b00;
    localparam logic [1:0] LAMP_RED    = 2'b01;
    localparam logic [1:0] LAMP_YELLOW = 2'b10;

    // Controller states; FLASH is only reachable when the flash feature is built in
    typedef enum logic [1:0] {
        ST_ALLRED = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_FLASH  = 2'd3
    } tlc_state_e;

endpackage

// File: rtl/tlc_rr_pick.sv
// Round-robin next-phase picker: first requesting approach after cur, wrapping through cur itself.
// Latency: purely combinational.
// Backpressure: none; with no request pending it simply advances to cur+1.
module tlc_rr_pick #(
    parameter int NUM_DIR = 4,
    localparam int PH_W = $clog2(NUM_DIR)
) (
    input  logic [NUM_DIR-1:0] req,
    input  logic [PH_W-1:0]    cur,
    output logic [PH_W-1:0]    nxt
);

    // Scan offsets 1..NUM_DIR from cur; the nearest requesting approach wins
    always_comb begin
        int   idx;
        logic found;
        found = 1'b0;
        idx   = int'(cur) + 1;
        if (idx >= NUM_DIR) idx = idx - NUM_DIR;
        nxt = idx[PH_W-1:0];
        for (int i = 1; i <= NUM_DIR; i++) begin
            idx = int'(cur) + i;
            if (idx >= NUM_DIR) idx = idx - NUM_DIR;
            if (!found && req[idx[PH_W-1:0]]) begin
                found = 1'b1;
                nxt   = idx[PH_W-1:0];
            end
        end
    end

endmodule

// File: rtl/traffic_light_ctrl_n.sv
// N-approach traffic-light controller: timed green/yellow/all-red phases, round-robin service, hold.
// Latency: lamps are Moore outputs of registered state; phase changes only on i_tick edges.
// Backpressure: none; i_hold freezes green, optional flash mode via macro TLC_FLASH_EN.
module traffic_light_ctrl_n
    import tlc_pkg::*;
#(
    parameter int NUM_DIR   = 4,
    parameter int CNT_W     = 8,
    parameter int GREEN_MIN = 10,
    parameter int GREEN_MAX = 40,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    localparam int PH_W = $clog2(NUM_DIR)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_tick,
    input  logic [NUM_DIR-1:0]   i_req,
    input  logic                 i_hold,
`ifdef TLC_FLASH_EN
    input  logic                 i_flash,
`endif
    output logic [2*NUM_DIR-1:0] o_light,
    output logic [PH_W-1:0]      o_phase
);

    // Last-tick thresholds: a state ends on the tick where the timer equals DUR-1
    localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] TMR_MAX   = '1;

    tlc_state_e          state_q, state_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [CNT_W-1:0]    timer_q;
    logic [PH_W-1:0]     rr_nxt;
    logic [NUM_DIR-1:0]  own_mask;
    logic                other;
    logic                gap_out;
    logic                max_out;

    tlc_rr_pick #(.NUM_DIR(NUM_DIR)) u_pick (
        .req (i_req),
        .cur (phase_q),
        .nxt (rr_nxt)
    );

    // State, phase and phase timer; the timer restarts on every state change and saturates
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_ALLRED;
            phase_q <= PH_W'(NUM_DIR - 1);
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            if (state_d != state_q)
                timer_q <= '0;
            else if (i_tick && timer_q != TMR_MAX)
                timer_q <= timer_q + 1'b1;
        end
    end

`ifdef TLC_FLASH_EN
    logic flash_tgl;

    // Flash blink phase: starts on YELLOW at entry and flips every tick while flashing
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            flash_tgl <= 1'b0;
        else if (state_q != ST_FLASH)
            flash_tgl <= 1'b0;
        else if (i_tick)
            flash_tgl <= ~flash_tgl;
    end
`endif

    // Next state: green exit by gap-out/max-out, fixed yellow and all-red clearance
    always_comb begin
        own_mask          = '0;
        own_mask[phase_q] = 1'b1;
        other             = |(i_req & ~own_mask);
        gap_out           = (timer_q >= GMIN_LAST) && !i_req[phase_q];
        max_out           = (timer_q >= GMAX_LAST);
        state_d           = state_q;
        phase_d           = phase_q;
        case (state_q)
            ST_GREEN: begin
                if (i_tick && !i_hold && other && (gap_out || max_out))
                    state_d = ST_YELLOW;
            end
            ST_YELLOW: begin
                if (i_tick && timer_q == YEL_LAST)
                    state_d = ST_ALLRED;
            end
            ST_ALLRED: begin
                if (i_tick && timer_q == AR_LAST) begin
`ifdef TLC_FLASH_EN
                    if (i_flash)
                        state_d = ST_FLASH;
                    else
`endif
                    begin
                        state_d = ST_GREEN;
                        phase_d = rr_nxt;
                    end
                end
            end
`ifdef TLC_FLASH_EN
            ST_FLASH: begin
                if (i_tick && !i_flash)
                    state_d = ST_ALLRED;
            end
`endif
            default: state_d = ST_ALLRED;
        endcase
    end

    // Lamp decode: everything RED except the owning approach in GREEN/YELLOW
    always_comb begin
        o_light = {NUM_DIR{LAMP_RED}};
        o_phase = phase_q;
        for (int k = 0; k < NUM_DIR; k++) begin
            if (PH_W'(k) == phase_q) begin
                if (state_q == ST_GREEN)
                    o_light[2*k +: 2] = LAMP_GREEN;
                else if (state_q == ST_YELLOW)
                    o_light[2*k +: 2] = LAMP_YELLOW;
            end
        end
`ifdef TLC_FLASH_EN
        if (state_q == ST_FLASH && !flash_tgl)
            o_light = {NUM_DIR{LAMP_YELLOW}};
`endif
    end

endmodule

// File: tb/tb_traffic_light_ctrl_n.sv
`timescale 1ns/1ps
module tb_traffic_light_ctrl_n;

    localparam int N    = 4;
    localparam int CW   = 5;
    localparam int GMIN = 4;
    localparam int GMAX = 8;
    localparam int YT   = 2;
    localparam int AT   = 1;

    // Reference model modes (bench-private encoding)
    localparam int M_ALLRED = 0;
    localparam int M_GREEN  = 1;
    localparam int M_YELLOW = 2;
    localparam int M_FLASH  = 3;

    typedef struct packed {
        logic [7:0] light;
        logic [1:0] phase;
    } exp_t;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_tick = 1'b0;
    logic         i_hold = 1'b0;
    logic [N-1:0] i_req = '0;
`ifdef TLC_FLASH_EN
    logic         i_flash = 1'b0;
`endif
    logic [2*N-1:0] o_light;
    logic [1:0]     o_phase;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    int m_mode;
    int m_phase;
    int m_cnt;

    always #5 i_clk = ~i_clk;

    traffic_light_ctrl_n #(
        .NUM_DIR(N), .CNT_W(CW), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX),
        .YELLOW_T(YT), .ALLRED_T(AT)
    ) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_tick (i_tick),
        .i_req  (i_req),
        .i_hold (i_hold),
`ifdef TLC_FLASH_EN
        .i_flash(i_flash),
`endif
        .o_light(o_light),
        .o_phase(o_phase)
    );

    function automatic int pick(input logic [N-1:0] req, input int cur);
        for (int off = 1; off <= N; off++)
            if (req[(cur + off) % N]) return (cur + off) % N;
        return (cur + 1) % N;
    endfunction

    task automatic model_reset();
        m_mode  = M_ALLRED;
        m_phase = N - 1;
        m_cnt   = 0;
    endtask

    // m_cnt = ticks already spent in the current mode (unbounded integer)
    task automatic model_step(input logic [N-1:0] req, input logic hold, input logic tick);
        bit others;
        if (!tick) return;
        case (m_mode)
            M_GREEN: begin
                others = 0;
                for (int d = 0; d < N; d++)
                    if (d != m_phase && req[d]) others = 1;
                m_cnt++;
                if (!hold && others && ((m_cnt >= GMIN && !req[m_phase]) || m_cnt >= GMAX)) begin
                    m_mode = M_YELLOW;
                    m_cnt  = 0;
                end
            end
            M_YELLOW: begin
                m_cnt++;
                if (m_cnt == YT) begin
                    m_mode = M_ALLRED;
                    m_cnt  = 0;
                end
            end
            M_ALLRED: begin
                m_cnt++;
                if (m_cnt == AT) begin
                    m_cnt = 0;
`ifdef TLC_FLASH_EN
                    if (i_flash) m_mode = M_FLASH;
                    else
`endif
                    begin
                        m_mode  = M_GREEN;
                        m_phase = pick(req, m_phase);
                    end
                end
            end
            default: begin
`ifdef TLC_FLASH_EN
                if (!i_flash) begin
                    m_mode = M_ALLRED;
                    m_cnt  = 0;
                end else begin
                    m_cnt++;
                end
`endif
            end
        endcase
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.light = 8'h55;
        e.phase = 2'(m_phase);
        if (m_mode == M_GREEN)       e.light[2*m_phase +: 2] = 2'b00;
        else if (m_mode == M_YELLOW) e.light[2*m_phase +: 2] = 2'b10;
        else if (m_mode == M_FLASH && (m_cnt % 2) == 0) e.light = 8'hAA;
        return e;
    endfunction

    // Drive one clock of stimulus and queue what the DUT must show after that edge
    task automatic cycle(input logic [N-1:0] req, input logic hold, input logic tick);
        @(posedge i_clk);
        #2;
        i_rst  = 1'b0;
        i_req  = req;
        i_hold = hold;
        i_tick = tick;
        model_step(req, hold, tick);
        exp_q.push_back(model_out());
    endtask

    // Asynchronous reset mid-cycle: outputs must collapse without waiting for a clock edge
    task automatic do_reset();
        exp_t e;
        @(posedge i_clk);
        #2;
        i_rst  = 1'b1;
        i_tick = 1'b0;
        model_reset();
        e = model_out();
        #1;
        checks++;
        if (o_light !== e.light || o_phase !== e.phase) begin
            errors++;
            $display("FAIL async_reset: light=%h phase=%0d, required light=%h phase=%0d",
                     o_light, o_phase, e.light, e.phase);
        end
        exp_q.push_back(e);
    endtask

    // Monitor: compare lamps/phase each cycle against the queued expectation
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                checks++;
                if (o_light !== mon_e.light || o_phase !== mon_e.phase) begin
                    errors++;
                    $display("FAIL lamps @%0t: light=%h phase=%0d, required light=%h phase=%0d",
                             $time, o_light, o_phase, mon_e.light, mon_e.phase);
                end
            end
        end
    end

    initial begin
        logic [N-1:0] rq;
        logic         hd;
        logic         tk;

        model_reset();
        exp_q.push_back(model_out());

        // Out of reset with no demand: one all-red tick then dir0 green
        repeat (4) cycle(4'b0000, 1'b0, 1'b1);

        // Gap-out from dir0 to dir2
        do_reset();
        cycle(4'b0000, 1'b0, 1'b1);
        repeat (10) cycle(4'b0100, 1'b0, 1'b1);

        // Max-out with own demand held: dir0 then dir1
        do_reset();
        repeat (15) cycle(4'b0011, 1'b0, 1'b1);

        // No other demand: green held; 32 ticks push a 5-bit timer past its top,
        // so a wrapping timer would delay the gap-out that follows
        do_reset();
        repeat (33) cycle(4'b0000, 1'b0, 1'b1);
        repeat (6) cycle(4'b0010, 1'b0, 1'b1);

        // Maintenance hold beyond max green, then release
        do_reset();
        cycle(4'b0000, 1'b0, 1'b1);
        repeat (20) cycle(4'b1000, 1'b1, 1'b1);
        repeat (6) cycle(4'b1000, 1'b0, 1'b1);

        // Reset in the middle of yellow, sequence restarts at dir0
        do_reset();
        cycle(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cycle(4'b0100, 1'b0, 1'b1);
            if (m_mode == M_YELLOW) break;
        end
        do_reset();
        repeat (3) cycle(4'b0000, 1'b0, 1'b1);

`ifdef TLC_FLASH_EN
        // Flash from reset, then back to normal service
        do_reset();
        i_flash = 1'b1;
        repeat (8) cycle(4'b0000, 1'b0, 1'b1);
        i_flash = 1'b0;
        repeat (6) cycle(4'b0010, 1'b0, 1'b1);
`endif

        // Randomised demand, hold and sparse ticks
        do_reset();
        rq = '0;
        hd = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(5) == 0) rq = 4'($urandom_range(15));
            if ($urandom_range(15) == 0) hd = ~hd;
            tk = ($urandom_range(3) != 0);
`ifdef TLC_FLASH_EN
            if ($urandom_range(63) == 0) i_flash = ~i_flash;
`endif
            cycle(rq, hd, tk);
        end

        @(posedge i_clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
